coin_change_dispenser: RTL

- Payout end of the coin path. The coin-acceptor front end adds inserted coins to a credit total; this block takes a change amount and ejects physical coins, one at a time, to a coin hopper until the amount is paid.
- Coins are selected greedy, largest first. Each eject strobe is handshaked against a hopper acknowledge.
- Reports completion, shortfall (amount not payable) and hopper jam.

---
 rtl/coin_pkg.sv | 35 +++
 rtl/coin_select.sv | 24 ++
 rtl/coin_change_dispenser.sv | 138 +++++++++++++
 3 files changed

// File: rtl/coin_pkg.sv
// Shared coin definitions for the payout and acceptor paths: coin values,
// the payout state encoding and the one-hot coin selection type.
package coin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_EJECT  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [6:0] VAL_D = 7'd100;
  localparam logic [6:0] VAL_Q = 7'd25;
  localparam logic [6:0] VAL_I = 7'd10;
  localparam logic [6:0] VAL_N = 7'd5;

  // One bit per coin, at most one set.
  typedef struct packed {
    logic d;
    logic q;
    logic i;
    logic n;
  } coin_sel_t;

  function automatic logic [6:0] coin_value(input coin_sel_t sel);
    logic [6:0] v;
    v = 7'd0;
    if (sel.d)      v = VAL_D;
    else if (sel.q) v = VAL_Q;
    else if (sel.i) v = VAL_I;
    else if (sel.n) v = VAL_N;
    return v;
  endfunction

endpackage

// File: rtl/coin_select.sv
// Combinational greedy picker: the largest coin that fits the remainder
// and whose tube still has stock; all-zero selection when nothing fits.
module coin_select
  import coin_pkg::*;
(
  input  logic [6:0] rem,
  input  logic       d_empty,
  input  logic       q_empty,
  input  logic       i_empty,
  input  logic       n_empty,
  output coin_sel_t  sel,
  output logic [6:0] value
);

  always_comb begin
    sel = '0;
    if (rem >= VAL_D && !d_empty)      sel.d = 1'b1;
    else if (rem >= VAL_Q && !q_empty) sel.q = 1'b1;
    else if (rem >= VAL_I && !i_empty) sel.i = 1'b1;
    else if (rem >= VAL_N && !n_empty) sel.n = 1'b1;
    value = coin_value(sel);
  end

endmodule

// File: rtl/coin_change_dispenser.sv
// Change payout: pays a latched amount as greedy coins, one eject strobe at
// a time, reporting done, shortfall and hopper jam.
module coin_change_dispenser
  import coin_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic       clk,
  input  logic       R,
  input  logic       start,
  input  logic [6:0] amount,
  input  logic       D_e,
  input  logic       Q_e,
  input  logic       I_e,
  input  logic       N_e,
  input  logic       coin_ack,
  output logic       D_o,
  output logic       Q_o,
  output logic       I_o,
  output logic       N_o,
  output logic       busy,
  output logic       done,
  output logic       short,
  output logic       jam,
  output logic [6:0] Remaining
);

  localparam logic [TW-1:0] TIMEOUT_CNT = TW'(TIMEOUT);

  // Hopper handshake: a strobe rises on entry to EJECT and is held until the
  // edge on which coin_ack is seen (coin paid) or the timer hits TIMEOUT
  // (jam); coin_ack in any other state is ignored.
  state_t        state_q, state_d;
  logic [6:0]    rem_q, rem_d;
  logic [6:0]    val_q, val_d;
  logic [TW-1:0] timer_q, timer_d;
  coin_sel_t     strobe_q, strobe_d;
  logic          short_q, short_d;
  logic          jam_q, jam_d;
  logic          busy_q, done_q;

  coin_sel_t     pick;
  logic [6:0]    pick_value;

  coin_select u_select (
    .rem     (rem_q),
    .d_empty (D_e),
    .q_empty (Q_e),
    .i_empty (I_e),
    .n_empty (N_e),
    .sel     (pick),
    .value   (pick_value)
  );

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      val_q    <= '0;
      timer_q  <= '0;
      strobe_q <= '0;
      short_q  <= 1'b0;
      jam_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      val_q    <= val_d;
      timer_q  <= timer_d;
      strobe_q <= strobe_d;
      short_q  <= short_d;
      jam_q    <= jam_d;
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    val_d    = val_q;
    timer_d  = timer_q;
    strobe_d = strobe_q;
    short_d  = short_q;
    jam_d    = jam_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d   = amount;
          short_d = 1'b0;
          jam_d   = 1'b0;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (rem_q == 7'd0) begin
          state_d = ST_DONE;
        end else if (pick == '0) begin
          short_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          strobe_d = pick;
          val_d    = pick_value;
          timer_d  = '0;
          state_d  = ST_EJECT;
        end
      end
      ST_EJECT: begin
        if (coin_ack) begin
          strobe_d = '0;
          rem_d    = rem_q - val_q;
          state_d  = ST_SELECT;
        end else if (timer_q == TIMEOUT_CNT) begin
          strobe_d = '0;
          jam_d    = 1'b1;
          state_d  = ST_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign D_o       = strobe_q.d;
  assign Q_o       = strobe_q.q;
  assign I_o       = strobe_q.i;
  assign N_o       = strobe_q.n;
  assign busy      = busy_q;
  assign done      = done_q;
  assign short     = short_q;
  assign jam       = jam_q;
  assign Remaining = rem_q;

endmodule
